fifo_reader: RTL and testbench

Read-side controller for the team's synchronous FIFO. It issues `read` pulses to the FIFO, respecting `fifo_empty`, and captures `buff_out` one cycle later into a 2-entry holding buffer. It presents the data to a downstream consumer over a valid/ready handshake, so the FIFO never loses or duplicates a word under backpressure. It sits between the FIFO's output side and any consumer block, and is the counterpart of the producer that drives `write`/`buff_in`.

---
 rtl/fifo_reader.sv | 99 +++++++++
 tb/tb_fifo_reader.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the synchronous FIFO.
// Pops words from the FIFO and captures each one, a cycle after its read,
// into a 2-entry holding buffer. The buffer is presented downstream over
// valid/ready. A read is only issued when the buffer is guaranteed room for
// the word, so backpressure never drops or duplicates data.
module fifo_reader #(
    parameter int DATA_SIZE = 4,
    parameter int CNT_SIZE  = 8
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 enable,
    input  logic                 fifo_empty,
    input  logic [DATA_SIZE-1:0] buff_out,
    output logic                 read,
    output logic [DATA_SIZE-1:0] data_out,
    output logic                 valid_out,
    input  logic                 ready_in,
    output logic                 busy,
    output logic [CNT_SIZE-1:0]  words_read
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t               r_state;
    logic [DATA_SIZE-1:0] r_mem [0:1];
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_occ;
    logic                 r_inflight;
    logic [CNT_SIZE-1:0]  r_words;

    logic                 w_pop;
    logic [2:0]           w_level;

    // Words committed to the buffer after this edge, counting the one
    // arriving from the FIFO and the one leaving downstream. A new read is
    // only safe when this leaves a free slot for the word it will return.
    assign valid_out = (r_occ != 2'd0);
    assign w_pop     = valid_out & ready_in;
    assign w_level   = {1'b0, r_occ} + {2'b00, r_inflight} - {2'b00, w_pop};

    // Enable is checked here as well so no read leaves in the cycle it drops.
    assign read       = (r_state == ST_RUN) & enable & ~fifo_empty & (w_level <= 3'd1);
    assign data_out   = valid_out ? r_mem[r_rptr] : '0;
    assign busy       = (r_state != ST_IDLE);
    assign words_read = r_words;

    // Control FSM: run fetches reads, drain empties the buffer before idling.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_state <= ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (enable) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    if (!enable) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (enable)
                        r_state <= ST_RUN;
                    else if (!r_inflight && (r_occ == 2'd0))
                        r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Buffer bookkeeping: in-flight flag, pointers, occupancy, read counter.
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            r_inflight <= 1'b0;
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_occ      <= 2'd0;
            r_words    <= '0;
        end else begin
            r_inflight <= read;
            if (r_inflight) r_wptr <= ~r_wptr;
            if (w_pop)      r_rptr <= ~r_rptr;
            r_occ <= r_occ + {1'b0, r_inflight} - {1'b0, w_pop};
            if (read) r_words <= r_words + 1'b1;
        end
    end

    // Storage: capture the FIFO word returned for last cycle's read.
    // No reset needed; data_out is masked while the buffer is empty.
    always_ff @(posedge clk) begin
        if (r_inflight) r_mem[r_wptr] <= buff_out;
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Testbench for fifo_reader: a behavioural FIFO model feeds the DUT and a
// capture queue records every word accepted downstream.
module tb_fifo_reader;

    localparam int DW = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          reset_L = 1'b0;
    logic          enable = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] buff_out = '0;
    logic          read;
    logic [DW-1:0] data_out;
    logic          valid_out;
    logic          ready_in = 1'b0;
    logic          busy;
    logic [CW-1:0] words_read;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] out_q  [$];
    int            rd_cnt = 0;
    int            underflow = 0;

    fifo_reader #(.DATA_SIZE(DW), .CNT_SIZE(CW)) dut (
        .clk        (clk),
        .reset_L    (reset_L),
        .enable     (enable),
        .fifo_empty (fifo_empty),
        .buff_out   (buff_out),
        .read       (read),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .ready_in   (ready_in),
        .busy       (busy),
        .words_read (words_read)
    );

    always #5 clk = ~clk;

    // FIFO model: data valid the cycle after read, empty flag registered
    always @(posedge clk) begin : fifo_model
        int n;
        n = fifo_q.size();
        if (read) begin
            rd_cnt++;
            if (n > 0) begin
                buff_out <= fifo_q[0];
                void'(fifo_q.pop_front());
                n--;
            end else begin
                underflow++;
            end
        end
        fifo_empty <= (n == 0);
    end

    // Downstream consumer capture
    always @(posedge clk) begin
        if (valid_out && ready_in) out_q.push_back(data_out);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        enable   = 1'b0;
        ready_in = 1'b0;
        reset_L  = 1'b0;
        fifo_q.delete();
        tick();
        tick();
        out_q.delete();
        rd_cnt    = 0;
        underflow = 0;
        reset_L   = 1'b1;
        tick();
    endtask

    // Push 1..n (low bits) into the FIFO model and let the empty flag update
    task automatic preload(input int n);
        for (int i = 1; i <= n; i++) fifo_q.push_back(DW'(i));
        tick();
    endtask

    task automatic test_reset();
        fifo_q.delete();
        for (int i = 1; i <= 4; i++) fifo_q.push_back(DW'(i));
        reset_L = 1'b0;
        for (int c = 0; c < 6; c++) begin
            enable   = 1'($urandom_range(0, 1));
            ready_in = 1'($urandom_range(0, 1));
            tick();
            n_tests++;
            if ({read, valid_out, data_out, busy, words_read} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0, {CW{1'b0}}}) begin
                n_fail++;
                $display("FAIL reset_hold c=%0d got read=%b valid=%b data=%h busy=%b words=%0d exp all 0",
                         c, read, valid_out, data_out, busy, words_read);
            end
        end
        $display("[TB] test_reset done");
    endtask

    task automatic test_streaming();
        logic exp_rd, exp_v;
        logic [DW-1:0] exp_d;
        do_reset();
        ready_in = 1'b1;
        preload(4);
        enable = 1'b1;                 // cycle 0
        for (int c = 1; c <= 7; c++) begin
            tick();
            exp_rd = (c >= 1 && c <= 4);
            exp_v  = (c >= 3 && c <= 6);
            exp_d  = exp_v ? DW'(c - 2) : '0;
            n_tests++;
            if (read !== exp_rd) begin
                n_fail++;
                $display("FAIL stream_read c=%0d got %b exp %b", c, read, exp_rd);
            end
            n_tests++;
            if ({valid_out, data_out} !== {exp_v, exp_d}) begin
                n_fail++;
                $display("FAIL stream_data c=%0d got v=%b d=%h exp v=%b d=%h", c, valid_out, data_out, exp_v, exp_d);
            end
        end
        n_tests++;
        if (words_read !== CW'(4)) begin
            n_fail++;
            $display("FAIL stream_words got %0d exp 4", words_read);
        end
        $display("[TB] test_streaming done, words_read=%0d", words_read);
    endtask

    task automatic test_backpressure();
        logic [4*DW-1:0] got;
        int cyc;
        do_reset();
        preload(4);
        enable = 1'b1;                 // cycle 0, ready_in=0
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c >= 3) begin
                n_tests++;
                if ({valid_out, data_out} !== {1'b1, DW'(1)}) begin
                    n_fail++;
                    $display("FAIL bp_hold c=%0d got v=%b d=%h exp v=1 d=1", c, valid_out, data_out);
                end
            end
        end
        n_tests++;
        if (rd_cnt !== 2) begin
            n_fail++;
            $display("FAIL bp_reads got %0d exp 2", rd_cnt);
        end
        ready_in = 1'b1;
        cyc = 0;
        while (out_q.size() < 4 && cyc < 20) begin
            tick();
            cyc++;
        end
        tick();
        tick();
        got = '0;
        for (int i = 0; i < out_q.size() && i < 4; i++) got[(3-i)*DW +: DW] = out_q[i];
        n_tests++;
        if (out_q.size() !== 4 || got !== {DW'(1), DW'(2), DW'(3), DW'(4)}) begin
            n_fail++;
            $display("FAIL bp_order got n=%0d words=%h exp n=4 words=1234", out_q.size(), got);
        end
        n_tests++;
        if (words_read !== CW'(4) || underflow !== 0) begin
            n_fail++;
            $display("FAIL bp_words got %0d underflow=%0d exp 4 underflow=0", words_read, underflow);
        end
        $display("[TB] test_backpressure done, delivered %0d words", out_q.size());
    endtask

    task automatic test_empty();
        do_reset();
        ready_in = 1'b1;
        enable   = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            tick();
            n_tests++;
            if ({read, valid_out, busy} !== 3'b001) begin
                n_fail++;
                $display("FAIL empty c=%0d got read=%b valid=%b busy=%b exp 0 0 1", c, read, valid_out, busy);
            end
        end
        $display("[TB] test_empty done");
    endtask

    task automatic test_disable_midstream();
        do_reset();
        ready_in = 1'b1;
        preload(4);
        enable = 1'b1;                 // cycle 0
        tick();                        // cycle 1: read
        tick();                        // cycle 2: read, inflight=1
        tick();                        // cycle 3: occ=1, inflight=1
        enable = 1'b0;
        #1;
        n_tests++;
        if (read !== 1'b0) begin
            n_fail++;
            $display("FAIL dis_noread c=3 got %b exp 0", read);
        end
        for (int c = 4; c <= 5; c++) begin
            tick();
            n_tests++;
            if ({read, busy} !== 2'b01) begin
                n_fail++;
                $display("FAIL dis_drain c=%0d got read=%b busy=%b exp 0 1", c, read, busy);
            end
        end
        tick();                        // cycle 6: IDLE
        n_tests++;
        if ({busy, valid_out} !== 2'b00) begin
            n_fail++;
            $display("FAIL dis_idle got busy=%b valid=%b exp 0 0", busy, valid_out);
        end
        n_tests++;
        if (out_q.size() !== 2 || words_read !== CW'(2)) begin
            n_fail++;
            $display("FAIL dis_words got n=%0d words_read=%0d exp 2 2", out_q.size(), words_read);
        end else begin
            n_tests++;
            if ({out_q[0], out_q[1]} !== {DW'(1), DW'(2)}) begin
                n_fail++;
                $display("FAIL dis_order got %h %h exp 1 2", out_q[0], out_q[1]);
            end
        end
        $display("[TB] test_disable_midstream done");
    endtask

    task automatic test_reset_midstream();
        do_reset();
        preload(4);
        enable = 1'b1;
        for (int c = 1; c <= 5; c++) tick();
        n_tests++;
        if ({valid_out, data_out, busy} !== {1'b1, DW'(1), 1'b1}) begin
            n_fail++;
            $display("FAIL rmid_pre got v=%b d=%h busy=%b exp 1 1 1", valid_out, data_out, busy);
        end
        #2;
        reset_L = 1'b0;
        #1;
        n_tests++;
        if ({read, valid_out, data_out, busy, words_read} !== {1'b0, 1'b0, {DW{1'b0}}, 1'b0, {CW{1'b0}}}) begin
            n_fail++;
            $display("FAIL rmid_async got read=%b v=%b d=%h busy=%b words=%0d exp all 0",
                     read, valid_out, data_out, busy, words_read);
        end
        tick();
        tick();
        n_tests++;
        if ({read, valid_out, busy} !== 3'b000) begin
            n_fail++;
            $display("FAIL rmid_hold got read=%b v=%b busy=%b exp 0 0 0", read, valid_out, busy);
        end
        reset_L = 1'b1;
        $display("[TB] test_reset_midstream done");
    endtask

    task automatic test_counter_wrap();
        int cyc;
        int bad;
        do_reset();
        ready_in = 1'b1;
        preload(256);
        enable = 1'b1;
        cyc = 0;
        while (rd_cnt < 255 && cyc < 400) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (words_read !== CW'(255)) begin
            n_fail++;
            $display("FAIL wrap_255 got %0d exp 255 (reads=%0d)", words_read, rd_cnt);
        end
        tick();
        n_tests++;
        if (rd_cnt !== 256 || words_read !== CW'(0)) begin
            n_fail++;
            $display("FAIL wrap_0 got %0d exp 0 (reads=%0d exp 256)", words_read, rd_cnt);
        end
        for (int c = 0; c < 5; c++) tick();
        bad = 0;
        for (int i = 0; i < out_q.size(); i++)
            if (out_q[i] !== DW'(i + 1)) bad++;
        n_tests++;
        if (out_q.size() !== 256 || bad !== 0) begin
            n_fail++;
            $display("FAIL wrap_data got n=%0d bad=%0d exp n=256 bad=0", out_q.size(), bad);
        end
        $display("[TB] test_counter_wrap done");
    endtask

    initial begin
        test_reset();
        reset_L = 1'b1;
        test_streaming();
        test_backpressure();
        test_empty();
        test_disable_midstream();
        test_reset_midstream();
        test_counter_wrap();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
